// File: rtl/trans_initiator.sv
// -----------------------------------------------------------------------------
// trans_initiator
//
// Driving end of the do_work/op_code/work_done transactor protocol. It picks
// one of NUM_CLIENTS requesters round-robin, sends that client's op_code to
// the responder with a one-cycle do_work pulse, waits for a fresh 0->1 edge
// on work_done, then pulses ack to the client. An op_code above MAX_OP is
// never sent to the responder; the client gets ack together with err.
//
// Optional build macro:
//   TRANS_INITIATOR_TIMEOUT_EN  - adds a WAIT watchdog. After TIMEOUT WAIT
//                                 cycles without completion the transaction
//                                 ends with ack + err.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous, active-high reset
//   req          in   per-client request level, held until ack
//   req_op       in   client i op_code at [i*OP_W +: OP_W]
//   ack          out  one-cycle completion pulse to the served client
//   err          out  one-cycle pulse with ack on reject or timeout
//   do_work      out  one-cycle issue pulse to the responder
//   op_code      out  op_code to the responder, latched at grant
//   work_done    in   responder completion level (0->1 edge completes)
//   busy         out  high in every state except IDLE
//   issue_count  out  transactions issued to the responder (wraps)
//
// state | meaning
// IDLE  | arbitrate among pending requests
// ISSUE | do_work pulse, issue_count increments
// WAIT  | wait for a work_done rising edge (or watchdog expiry)
// DONE  | ack the winner, err on reject/timeout, advance rr pointer
// -----------------------------------------------------------------------------
module trans_initiator #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned OP_W        = 11,
  parameter int unsigned MAX_OP      = 1255,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CLIENTS-1:0]      req,
  input  logic [NUM_CLIENTS*OP_W-1:0] req_op,
  output logic [NUM_CLIENTS-1:0]      ack,
  output logic                        err,
  output logic                        do_work,
  output logic [OP_W-1:0]             op_code,
  input  logic                        work_done,
  output logic                        busy,
  output logic [31:0]                 issue_count
);

  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);
  // One extra bit so MAX_OP compares safely against any OP_W-bit op_code.
  localparam logic [OP_W:0] MAX_OP_L = (OP_W+1)'(MAX_OP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_winner;
  logic [OP_W-1:0]   r_op_code;
  logic              r_reject;
  logic              r_timeout;
  logic              r_wd_q;
  logic [31:0]       r_issue_count;

  logic              w_grant_vld;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [OP_W-1:0]   w_grant_op;
  logic              w_grant_over;
  logic              w_complete;
  logic              w_tmo_hit;

  // Rotating priority: scan from the highest offset down so the requester
  // closest to r_rr_ptr (offset 0) is the last to overwrite and wins.
  always_comb begin
    int v_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_idx       = 0;
    for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
      v_idx = (int'(r_rr_ptr) + k) % int'(NUM_CLIENTS);
      if (req[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_idx[IDX_W-1:0];
      end
    end
  end

  assign w_grant_op   = req_op[int'(w_grant_idx)*OP_W +: OP_W];
  assign w_grant_over = ({1'b0, w_grant_op} > MAX_OP_L);

  // wd_q follows work_done every cycle, so a level already high when WAIT
  // is entered never counts as completion; only a fresh edge does.
  assign w_complete = (r_state == S_WAIT) && !r_wd_q && work_done;

`ifdef TRANS_INITIATOR_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic [31:0] w_tmo_cnt_nxt;

  // The count seen in a WAIT cycle is r_tmo_cnt + 1, so the first WAIT
  // cycle counts as 1 and expiry lands exactly TIMEOUT cycles after entry.
  assign w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
  assign w_tmo_hit     = (r_state == S_WAIT) && (w_tmo_cnt_nxt == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = w_grant_over ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_complete || w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_op_code     <= '0;
      r_reject      <= 1'b0;
      r_timeout     <= 1'b0;
      r_wd_q        <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wd_q  <= work_done;
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_winner  <= w_grant_idx;
            r_op_code <= w_grant_op;
            r_reject  <= w_grant_over;
            r_timeout <= 1'b0;
          end
        end
        S_ISSUE: r_issue_count <= r_issue_count + 32'd1;
        S_WAIT: begin
          // Completion in the expiry cycle wins, so no error is flagged.
          if (w_tmo_hit && !w_complete) begin
            r_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_winner == IDX_W'(NUM_CLIENTS - 1)) begin
            r_rr_ptr <= '0;
          end else begin
            r_rr_ptr <= r_winner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (r_state == S_DONE) begin
      ack[r_winner] = 1'b1;
    end
  end

  assign err         = (r_state == S_DONE) && (r_reject || r_timeout);
  assign do_work     = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign op_code     = r_op_code;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_trans_initiator.sv
// -----------------------------------------------------------------------------
// tb_trans_initiator
//
// Scoreboard bench for trans_initiator. Each batch of requests is turned into
// an expected sequence of completions by a transaction-level round-robin
// model; a monitor pops one entry per ack and compares client, err, the
// do_work/op_code that preceded it and issue_count. Directed cases cover the
// cycle timing, reject, stale/spurious work_done, watchdog and reset.
// -----------------------------------------------------------------------------
module tb_trans_initiator;

  localparam int N     = 4;
  localparam int OW    = 11;
  localparam int MAXOP = 1255;
  localparam int TMO   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*OW-1:0] req_op = '0;
  logic            work_done = 1'b0;
  logic [N-1:0]    ack;
  logic            err;
  logic            do_work;
  logic [OW-1:0]   op_code;
  logic            busy;
  logic [31:0]     issue_count;

  trans_initiator #(
    .NUM_CLIENTS(N),
    .OP_W       (OW),
    .MAX_OP     (MAXOP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .ack        (ack),
    .err        (err),
    .do_work    (do_work),
    .op_code    (op_code),
    .work_done  (work_done),
    .busy       (busy),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            client;
    logic [OW-1:0] op;
    bit            dw;
    bit            err;
    logic [31:0]   cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_rr = 0;
  logic [31:0] m_cnt = '0;
  bit          auto_resp = 1'b0;
  int          resp_phase = 0;
  int          resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: one scoreboard entry per ack.
  initial begin
    int            seen_dw;
    logic [OW-1:0] seen_op;
    logic [N-1:0]  exp_ack;
    exp_t          e;
    seen_dw = 0;
    seen_op = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_dw = 0;
      end else begin
        if (do_work) begin
          seen_dw++;
          seen_op = op_code;
        end
        if (ack != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ack", ack, 0);
          end else begin
            e = sb_q.pop_front();
            exp_ack = '0;
            exp_ack[e.client] = 1'b1;
            check("ack_client", ack, exp_ack);
            check("ack_err", err, e.err);
            check("do_work_count", seen_dw, e.dw ? 1 : 0);
            if (e.dw) check("issued_op", seen_op, e.op);
            check("issue_count", issue_count, e.cnt);
          end
          seen_dw = 0;
        end
      end
    end
  end

  // One cycle: clients drop req on ack, auto responder raises work_done
  // 1..4 WAIT cycles after do_work and drops it once ack is seen.
  task automatic step();
    @(negedge clk);
    if (ack != '0) req = req & ~ack;
    if (resp_phase == 2 && ack != '0) begin
      work_done  = 1'b0;
      resp_phase = 0;
    end
    if (resp_phase == 1) begin
      if (resp_cnt == 0) begin
        work_done  = 1'b1;
        resp_phase = 2;
      end else begin
        resp_cnt--;
      end
    end
    if (auto_resp && do_work) begin
      resp_phase = 1;
      resp_cnt   = $urandom_range(0, 3);
    end
  endtask

  // Reference model: requests held until served are granted in rotating
  // order starting at the model pointer.
  task automatic launch(input logic [N-1:0] mask, input logic [N*OW-1:0] ops, input bit tmo);
    logic [N-1:0] pend;
    exp_t e;
    pend = mask;
    while (pend != '0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (pend[i]) begin
          e.client = i;
          e.op     = ops[i*OW +: OW];
          e.dw     = (int'(e.op) <= MAXOP);
          e.err    = !e.dw || tmo;
          if (e.dw) m_cnt = m_cnt + 1;
          e.cnt    = m_cnt;
          sb_q.push_back(e);
          pend[i]  = 1'b0;
          m_rr     = (i + 1) % N;
          break;
        end
      end
    end
    req_op = ops;
    req    = mask;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (!(sb_q.size() == 0 && !busy && req == '0) && c < budget) begin
      step();
      c++;
    end
    check({name, "_complete"}, (sb_q.size() == 0 && !busy && req == '0), 1);
  endtask

  task automatic wait_dw(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (do_work) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_do_work_seen"}, ok, 1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    work_done  = 1'b0;
    resp_phase = 0;
    step();
    reset = 1'b0;
    sb_q.delete();
    m_rr  = 0;
    m_cnt = '0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ack"}, ack, 0);
    check({name, "_err"}, err, 0);
    check({name, "_do_work"}, do_work, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_op_code"}, op_code, 0);
    check({name, "_issue_count"}, issue_count, 0);
  endtask

  initial begin
    logic [N-1:0]    mask;
    logic [N*OW-1:0] ops;
    int              cyc_low;

    repeat (3) step();
    check_reset_outputs("por");
    do_reset();

    // Single client, work_done rises in the third WAIT cycle.
    auto_resp = 1'b0;
    launch(4'b0001, {11'd0, 11'd0, 11'd0, 11'd5}, 1'b0);
    wait_dw("t1", 10);
    check("t1_op_code", op_code, 5);
    repeat (3) step();
    work_done = 1'b1;
    check("t1_no_early_ack", ack, 0);
    step();
    check("t1_ack", ack, 4'b0001);
    check("t1_err", err, 0);
    check("t1_issue_count", issue_count, 1);
    work_done = 1'b0;
    step();
    check("t1_idle", busy, 0);

    // Simultaneous requests from rr_ptr=0, then clients 1 and 3.
    do_reset();
    auto_resp = 1'b1;
    launch(4'b1111, {11'd13, 11'd12, 11'd11, 11'd10}, 1'b0);
    wait_idle("rr4", 200);
    launch(4'b1010, {11'd23, 11'd0, 11'd21, 11'd0}, 1'b0);
    wait_idle("rr2", 200);

    // Reject: ack+err one cycle after grant, nothing issued.
    launch(4'b0100, {11'd0, 11'd1256, 11'd0, 11'd0}, 1'b0);
    step();
    check("rej_ack", ack, 4'b0100);
    check("rej_err", err, 1);
    check("rej_no_do_work", do_work, 0);
    check("rej_issue_count", issue_count, m_cnt);
    step();
    check("rej_idle", busy, 0);
    launch(4'b0001, {11'd0, 11'd0, 11'd0, 11'd1255}, 1'b0);
    wait_idle("max_op", 50);

    // work_done edges in IDLE, then a level already high at WAIT entry.
    auto_resp = 1'b0;
    work_done = 1'b1;
    step();
    step();
    work_done = 1'b0;
    step();
    work_done = 1'b1;
    step();
    step();
    check("spur_idle_busy", busy, 0);
    launch(4'b0001, {11'd0, 11'd0, 11'd0, 11'd20}, 1'b0);
    wait_dw("stale", 10);
    repeat (4) step();
    check("stale_no_ack", ack, 0);
    check("stale_busy", busy, 1);
    work_done = 1'b0;
    step();
    work_done = 1'b1;
    step();
    check("fresh_edge_ack", ack, 4'b0001);
    work_done = 1'b0;
    step();

`ifdef TRANS_INITIATOR_TIMEOUT_EN
    launch(4'b0001, {11'd0, 11'd0, 11'd0, 11'd3}, 1'b1);
    wait_dw("tmo", 10);
    repeat (TMO) step();
    check("tmo_no_early_ack", ack, 0);
    step();
    check("tmo_ack", ack, 4'b0001);
    check("tmo_err", err, 1);
    step();
`else
    launch(4'b0001, {11'd0, 11'd0, 11'd0, 11'd3}, 1'b0);
    wait_dw("hold", 10);
    cyc_low = 0;
    repeat (1000) begin
      step();
      if (!busy) cyc_low++;
    end
    check("hold_busy_cycles_low", cyc_low, 0);
`endif

    // Reset during WAIT abandons the transaction.
    do_reset();
    launch(4'b0010, {11'd0, 11'd0, 11'd9, 11'd0}, 1'b0);
    wait_dw("rst", 10);
    step();
    step();
    do_reset();
    check_reset_outputs("rst_wait");
    work_done = 1'b1;
    step();
    work_done = 1'b0;
    step();
    check("rst_late_edge_ignored", busy, 0);
    auto_resp = 1'b1;
    launch(4'b0010, {11'd0, 11'd0, 11'd7, 11'd0}, 1'b0);
    wait_idle("post_rst", 50);

    // Random batches.
    repeat (40) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) ops[i*OW +: OW] = 11'($urandom_range(1250, 1260));
        else                           ops[i*OW +: OW] = 11'($urandom_range(0, MAXOP));
      end
      launch(mask, ops, 1'b0);
      wait_idle("rand", 200);
    end

    step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trans_initiator.md
# trans_initiator

Clocked initiator for the do_work/op_code/work_done transactor protocol: the driving end that the `trans` responder services. Arbitrates round-robin among NUM_CLIENTS requesters, drives one op_code per transaction with a one-cycle do_work pulse, and waits for the responder's work_done rising edge. It then acknowledges the winning client. One instance sits in front of each `trans` responder in the test harness.

## Interface
- NUM_CLIENTS, 4: number of requesting clients (2..16).
- OP_W, 11: op_code width.
- MAX_OP, 1255: highest legal op_code (responder totals depth − 1).
- TIMEOUT, 255: WAIT-state cycle limit (used only with the watchdog enabled).

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_CLIENTS  per-client request level, held until ack.
- req_op  in  NUM_CLIENTS*OP_W  client i op_code at bits [i*OP_W +: OP_W].
- ack  out  NUM_CLIENTS  one-cycle completion pulse to the served client.
- err  out  1  one-cycle pulse coincident with ack on reject or timeout.
- do_work  out  1  one-cycle issue pulse to the responder.
- op_code  out  OP_W  op_code to the responder, held from ISSUE until the next grant.
- work_done  in  1  responder completion level; completion is a 0→1 transition.
- busy  out  1  high in any state except IDLE.
- issue_count  out  32  transactions issued to the responder.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is set, grant the first requester at or after rr_ptr, cyclically. Latch the winner index and its op_code.
  - If op_code > MAX_OP, go to DONE with the reject flag set. No issue occurs.
  - Otherwise go to ISSUE.
- ISSUE: do_work=1 for exactly this cycle. issue_count increments, wrapping 0xFFFFFFFF→0. Go to WAIT.
- WAIT: work_done is registered into wd_q. Completion occurs when wd_q=0 and work_done=1; then go to DONE.
- DONE: ack[winner]=1. err=reject|timeout. rr_ptr becomes winner+1 mod NUM_CLIENTS. Go to IDLE.
- A req still high in the cycle after ack counts as a new request. Clients drop req in the ack cycle to avoid a repeat.
- req changes in ISSUE, WAIT and DONE are ignored. Rising edges of work_done outside WAIT are ignored.
- Reset values:
  - state=IDLE, rr_ptr=0, wd_q=0.
  - do_work=0, ack=0, err=0, busy=0, op_code=0, issue_count=0.
  - Timeout counter=0.
- Reset mid-transaction abandons the transaction with no ack. A later work_done edge is ignored unless a new WAIT is entered.

## Timing
- With req seen in IDLE at cycle t:
  - do_work is asserted at t+1.
  - WAIT begins at t+2.
  - If completion is detected at cycle w, ack is asserted at w+1 and IDLE resumes at w+2.
- Minimum transaction, with work_done rising in the first WAIT cycle: 4 cycles from req sampled to IDLE.
- Reject path: IDLE(t) → DONE(t+1) with ack+err → IDLE(t+2).
- op_code is valid one cycle before do_work is sampled by the responder, because it is latched at grant.
- Simultaneous requests resolve in rotating order. No client waits more than NUM_CLIENTS−1 transactions.

## Configuration
- TRANS_INITIATOR_TIMEOUT_EN defined: WAIT counts cycles from 1. If the count reaches TIMEOUT with no completion, go to DONE with err=1.
  - If completion and count==TIMEOUT occur in the same cycle, completion wins and err=0.
  - The counter clears on entry to WAIT.
- Not defined: no counter. WAIT holds indefinitely, and err is asserted only on reject.

## Test plan
- Single client, req[0] with op 5, work_done rising 3 cycles after do_work:
  - do_work pulses once and op_code=5.
  - ack[0] one cycle after the rise, err=0, issue_count=1.
- All four req set with ops 10, 11, 12, 13 and rr_ptr=0:
  - Issues in order 10, 11, 12, 13 with acks 0, 1, 2, 3.
  - Then req[1] and req[3] only: client 1 served before client 3.
- req[2] with op 1256:
  - No do_work; ack[2] and err at t+1; issue_count unchanged.
- work_done already high, or a spurious rise while IDLE:
  - No ack.
  - Next transaction completes only on a fresh 0→1 edge.
- TIMEOUT_EN with TIMEOUT=8 and work_done held low:
  - ack and err exactly 8 WAIT cycles after entry.
  - Without the macro, busy stays high for 1000 cycles.
- reset asserted during WAIT:
  - Next cycle: all outputs at reset values and no ack.
  - A subsequent req[1] op 7 completes normally with issue_count=1.
